// File: rtl/iir_ctrl_pkg.sv
// Shared constants, coefficient addressing and FSM encoding for the IIR filter controller.
package iir_ctrl_pkg;

  localparam int NB_DEF = 12;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_B0 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_B1 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_B2 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_A1 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_A2 = 3'd4;

  // Bank packing: f_b carries three feed-forward taps, f_a two feedback taps.
  localparam int N_B    = 3;
  localparam int N_A    = 2;
  localparam int N_COEF = N_B + N_A;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    DRAIN,
    LOAD,
    FLUSH
  } state_t;

endpackage

// File: rtl/iir_ctrl_if.sv
// Sample, configuration and filter-side signals of the IIR controller.
interface iir_ctrl_if #(
  parameter int NB = 12
);
  logic                 cfg_we;
  logic [2:0]           cfg_addr;
  logic signed [NB-1:0] cfg_data;
  logic                 cfg_commit;
  logic                 cfg_flush;
  logic                 cfg_busy;
  logic                 s_valid;
  logic signed [NB-1:0] s_data;
  logic                 s_ready;
  logic                 f_vIn;
  logic signed [NB-1:0] f_dIn;
  logic [3*NB-1:0]      f_b;
  logic [2*NB-1:0]      f_a;
  logic                 f_rst_n;
  logic                 f_vOut;
  logic                 err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_commit, cfg_flush, s_valid, s_data, f_vOut,
    input  cfg_busy, s_ready, f_vIn, f_dIn, f_b, f_a, f_rst_n, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_commit, cfg_flush, s_valid, s_data, f_vOut,
    output cfg_busy, s_ready, f_vIn, f_dIn, f_b, f_a, f_rst_n, err
  );
endinterface

// File: rtl/iir_coeff_bank.sv
// Shadow/active coefficient registers; the active bank only moves on the load strobe.
module iir_coeff_bank
  import iir_ctrl_pkg::*;
#(
  parameter int NB = NB_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic signed [NB-1:0] wdata,
  input  logic                 load,
  output logic [N_B*NB-1:0]    f_b,
  output logic [N_A*NB-1:0]    f_a
);

  logic signed [NB-1:0] shadow [N_COEF];
  logic signed [NB-1:0] active [N_COEF];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_COEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // Addresses above a2 are silently dropped.
      if (we && (addr <= ADDR_A2))
        shadow[addr] <= wdata;
      if (load)
        for (int i = 0; i < N_COEF; i++)
          active[i] <= shadow[i];
    end
  end

  assign f_b = {active[ADDR_B2], active[ADDR_B1], active[ADDR_B0]};
  assign f_a = {active[ADDR_A2], active[ADDR_A1]};

endmodule

// File: rtl/iir_ctrl.sv
// Sample forwarder and coefficient-swap sequencer sitting in front of the IIR datapath.
module iir_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int NB           = NB_DEF,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  iir_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] FLUSH_C = CNT_W'(FLUSH_CYCLES);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     flush_cnt;
  logic                 flush_lat;
  logic                 err_q;
  logic                 vld_p1;
  logic signed [NB-1:0] dat_p1;

  logic s_ready_c, busy_c, f_rst_n_c;
  logic accept, vout_dec, cfg_wr, bank_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    state_nxt = RUN;
      RUN:     if (bus.cfg_commit) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && !vld_p1) state_nxt = LOAD;
      LOAD:    state_nxt = flush_lat ? FLUSH : RUN;
      FLUSH:   if (flush_cnt == '0) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    s_ready_c = 1'b0;
    busy_c    = 1'b0;
    f_rst_n_c = 1'b1;
    unique case (state)
      INIT:        f_rst_n_c = 1'b0;
      RUN:         s_ready_c = (inflight < MAX_C);
      DRAIN, LOAD: busy_c    = 1'b1;
      FLUSH: begin
        busy_c    = 1'b1;
        f_rst_n_c = 1'b0;
      end
      default: f_rst_n_c = 1'b0;
    endcase
  end

  assign accept    = bus.s_valid && s_ready_c;
  // A return pulse with nothing outstanding is flagged, never allowed to underflow.
  assign vout_dec  = bus.f_vOut && (inflight != '0);
  assign cfg_wr    = bus.cfg_we && !busy_c;
  assign bank_load = (state == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= '0;
      err_q     <= 1'b0;
      flush_lat <= 1'b0;
      flush_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(vout_dec);
      if (bus.f_vOut && (inflight == '0))
        err_q <= 1'b1;
      if ((state == RUN) && bus.cfg_commit)
        flush_lat <= bus.cfg_flush;
      if (state == LOAD)
        flush_cnt <= FLUSH_C - 1'b1;
      else if ((state == FLUSH) && (flush_cnt != '0))
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // Stage p1: accepted sample registered towards the filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept)
        dat_p1 <= bus.s_data;
    end
  end

  iir_coeff_bank #(
    .NB(NB)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_wr),
    .addr (bus.cfg_addr),
    .wdata(bus.cfg_data),
    .load (bank_load),
    .f_b  (bus.f_b),
    .f_a  (bus.f_a)
  );

  assign bus.s_ready  = s_ready_c;
  assign bus.cfg_busy = busy_c;
  assign bus.f_rst_n  = f_rst_n_c;
  assign bus.f_vIn    = vld_p1;
  assign bus.f_dIn    = dat_p1;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_iir_ctrl.sv
// Directed bench for iir_ctrl: sample scoreboard plus cycle-exact swap/flush checks.
module tb_iir_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_ctrl_if #(.NB(12)) bus ();

  iir_ctrl #(
    .NB          (12),
    .MAX_INFLIGHT(4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic signed [11:0] sb_q[$];
  logic [15:0]        vpipe = '0;
  logic [3:0]         echo_idx = 4'd0;
  logic               echo_en = 1'b1;
  logic               spur = 1'b0;
  int                 acc;

  // Filter model: echo each f_vIn back as f_vOut echo_idx+1 cycles later.
  always @(posedge clk) vpipe <= {vpipe[14:0], bus.f_vIn & echo_en};
  assign bus.f_vOut = vpipe[echo_idx] | spur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push what the DUT will capture, pop when it forwards a sample.
  always @(negedge clk) begin
    #2;
    if (bus.f_vIn === 1'b1) begin
      tests++;
      assert (sb_q.size() != 0)
      else begin
        fails++;
        $error("FAIL sb_pop: observed f_vIn with empty queue, required no sample");
      end
      if (sb_q.size() != 0) chk("sb_data", bus.f_dIn, sb_q.pop_front());
    end
    if (!rst && bus.s_valid && bus.s_ready) sb_q.push_back(bus.s_data);
  end

  task automatic step();
    @(posedge clk);
    #1 bus.s_data = bus.s_data + 12'h035;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
    bus.cfg_commit = 0; bus.cfg_flush = 0;
    bus.s_valid = 1'b1; bus.s_data = 12'h001;
    step(); step();

    chk("rst_f_rst_n", bus.f_rst_n, 0);
    chk("rst_f_vIn",   bus.f_vIn, 0);
    chk("rst_f_dIn",   bus.f_dIn, 0);
    chk("rst_busy",    bus.cfg_busy, 0);
    chk("rst_err",     bus.err, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_f_b",     bus.f_b, 0);
    chk("rst_f_a",     bus.f_a, 0);

    // Release reset just after an edge: one INIT cycle, then RUN.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("init_f_rst_n", bus.f_rst_n, 0);
    chk("init_s_ready", bus.s_ready, 0);
    step();
    chk("run_f_rst_n", bus.f_rst_n, 1);
    chk("run_s_ready", bus.s_ready, 1);
    chk("run_f_vIn0",  bus.f_vIn, 0);
    step();
    chk("stream_start", bus.f_vIn, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stream_f_vIn", bus.f_vIn, 1);
      chk("stream_ready", bus.s_ready, 1);
      chk("stream_f_b",   bus.f_b, 0);
      chk("stream_f_a",   bus.f_a, 0);
    end

    // Commit without flush, three samples outstanding, returns delayed 5 cycles.
    bus.s_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("idle_ready", bus.s_ready, 1);
    echo_idx = 4'd4;
    cfg_write(3'd0, 12'h100);
    cfg_write(3'd1, 12'h080);
    cfg_write(3'd3, 12'hF00);
    bus.s_valid = 1'b1;
    step();
    step();
    bus.cfg_commit = 1'b1;
    bus.cfg_flush  = 1'b0;
    step();
    bus.cfg_commit = 1'b0;
    bus.s_valid    = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      chk("c0_busy",    bus.cfg_busy, (i <= 7));
      chk("c0_s_ready", bus.s_ready, (i >= 8));
      chk("c0_f_rst_n", bus.f_rst_n, 1);
      chk("c0_f_b",     bus.f_b, (i >= 8) ? 36'h000080100 : 36'h0);
      chk("c0_f_a",     bus.f_a, (i >= 8) ? 24'h000F00 : 24'h0);
      step();
    end

    // Commit with flush; writes, re-commit and a stray f_vOut hit the busy window.
    cfg_write(3'd4, 12'h123);
    bus.s_valid    = 1'b1;
    bus.cfg_commit = 1'b1;
    bus.cfg_flush  = 1'b1;
    step();
    bus.s_valid    = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.cfg_flush  = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk("c1_busy",    bus.cfg_busy, (i <= 9));
      chk("c1_f_rst_n", bus.f_rst_n, !((i == 8) || (i == 9)));
      chk("c1_s_ready", bus.s_ready, (i == 10));
      chk("c1_f_b",     bus.f_b, 36'h000080100);
      chk("c1_f_a",     bus.f_a, (i >= 8) ? 24'h123F00 : 24'h000F00);
      chk("c1_err",     bus.err, (i >= 9));
      if (i == 0) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 12'h7FF;
        bus.cfg_commit = 1'b1;
      end
      if (i == 1) begin
        bus.cfg_we = 1'b0;
        bus.cfg_commit = 1'b0;
      end
      if (i == 8) spur = 1'b1;
      if (i == 9) spur = 1'b0;
      step();
    end
    chk("c1_no_recommit", bus.cfg_busy, 0);

    // In-flight ceiling with returns withheld.
    echo_en = 1'b0;
    bus.s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.s_ready) acc++;
      step();
    end
    chk("max_accepts", acc, 4);
    chk("max_ready",   bus.s_ready, 0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.s_ready) acc++;
      step();
    end
    chk("one_more_accept", acc, 1);
    chk("err_sticky",      bus.err, 1);

    // Drain by hand, then reset while the filter is being flushed.
    bus.s_valid = 1'b0;
    spur = 1'b1;
    for (int i = 0; i < 4; i++) step();
    spur = 1'b0;
    chk("drained_ready", bus.s_ready, 1);
    cfg_write(3'd2, 12'h055);
    bus.cfg_commit = 1'b1;
    bus.cfg_flush  = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
    bus.cfg_flush  = 1'b0;
    step();
    step();
    chk("fl_f_rst_n", bus.f_rst_n, 0);
    chk("fl_busy",    bus.cfg_busy, 1);
    chk("fl_f_b",     bus.f_b, 36'h055080100);
    #1 rst = 1'b1;
    #1;
    chk("arst_f_rst_n", bus.f_rst_n, 0);
    chk("arst_busy",    bus.cfg_busy, 0);
    chk("arst_f_b",     bus.f_b, 0);
    chk("arst_f_a",     bus.f_a, 0);
    chk("arst_f_vIn",   bus.f_vIn, 0);
    chk("arst_f_dIn",   bus.f_dIn, 0);
    chk("arst_err",     bus.err, 0);
    chk("arst_s_ready", bus.s_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rinit_f_rst_n", bus.f_rst_n, 0);
    step();
    chk("rrun_f_rst_n", bus.f_rst_n, 1);
    chk("rrun_busy",    bus.cfg_busy, 0);
    chk("rrun_f_b",     bus.f_b, 0);
    step();
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
